sar_avg: RTL and testbench
==========================

// Module: sar_avg
// PURPOSE
//  Post-SAR averaging stage. Consumes per-channel ADC reports from the DAC mux/SAR
//  sequencer (one pulse per finished conversion). Accumulates 2^NAVG reports per channel,
//  emits a rounded 10-bit average, and optionally raises window-compare status and INT.
// PARAMETERS
//  BIT_PTR  5   width of channel index
//  N_CHNL   18  number of channels with accumulators (< 2^BIT_PTR)
//  N_STA    8   channels 0..N_STA-1 have window status bits
// PORTS
//  clk        in   1        system clock
//  srst       in   1        synchronous reset, active-high
//  i_rpt_vld  in   1        1-cycle pulse, conversion report valid
//  i_rpt_ch   in   BIT_PTR  channel of report
//  i_rpt_v    in   10       SAR report value
//  r_wr       in   4        SFR strobes: [0]AVGCTL [1]WINLO [2]WINHI [3]AVGSTA(W1C)
//  r_wdat     in   8        SFR write data
//  o_avgctl   out  8        AVGCTL readback {5'h0, en, navg[1:0]}; clr bit reads 0
//  o_winlo    out  8        WINLO readback
//  o_winhi    out  8        WINHI readback
//  o_avgsta   out  N_STA    window status, sticky
//  o_avg_vld  out  1        1-cycle pulse, new average
//  o_avg_ch   out  BIT_PTR  channel of o_avg_v
//  o_avg_v    out  10       rounded average
//  o_intr     out  1        |o_avgsta
// BEHAVIOUR
//  - Reset: all accumulators, counters, AVGCTL, o_avgsta, o_avg_* cleared to 0.
//    WINLO resets to 8'h00 and WINHI to 8'hff, so nothing is out of window.
//  - AVGCTL: bit0 = clr (self-clearing), bits[2:1] = navg, bit3 = en.
//    Any AVGCTL write zeroes every acc/cnt, which makes a navg change safe.
//  - Per channel: acc[12:0] and cnt[2:0] are held in flops. A single-cycle
//    read-modify-write means back-to-back same-channel reports need no forwarding.
//  - A report is accepted when i_rpt_vld & en & (i_rpt_ch < N_CHNL). Otherwise it is
//    dropped silently.
//  - On accept: sum = acc[ch] + i_rpt_v.
//    - If cnt[ch] == 2^navg-1: o_avg_v <= (sum + (2^navg>>1)) >> navg, o_avg_vld <= 1,
//      o_avg_ch <= ch, and acc/cnt[ch] <= 0.
//    - Else: acc[ch] <= sum, cnt[ch] <= cnt+1.
//  - Latency: o_avg_vld is asserted the cycle after the completing i_rpt_vld.
//  - Arithmetic: the 13-bit sum cannot overflow (8*1023+4 < 8192), so no saturation.
//  - navg = 0: o_avg_v = i_rpt_v, pass-through with 1-cycle latency.
//  - Simultaneous AVGCTL write and accepted report: the write wins and the report is dropped.
//    o_avg_vld stays 0 that cycle.
//  - en = 0: o_avg_* hold their last value; o_avg_vld stays 0.
//  - Channel index wraps nowhere; out-of-range indices are ignored.
// CONFIGURATION
//  SAR_AVG_WINDOW_EN defined:
//   - On each o_avg_vld with ch < N_STA: out = (avg[9:2] < WINLO) | (avg[9:2] > WINHI).
//     If out, o_avgsta[ch] is set in the same cycle o_avg_vld rises.
//   - AVGSTA write clears bits where r_wdat = 1.
//   - Set beats clear in the same cycle on the same bit.
//  SAR_AVG_WINDOW_EN undefined:
//   - WINLO/WINHI registers are removed and read 0.
//   - o_avgsta = 0 and o_intr = 0; writes to r_wr[1..3] are ignored.
// STRUCTURE
//  - Shared package: AVGCTL bit-position constants, the SFR strobe index map,
//    and ACC_W = 13, CNT_W = 3.
//  - One sub-module, sar_avg_win: window compare plus sticky W1C status, instantiated
//    only under SAR_AVG_WINDOW_EN. Accumulator bank and rounding live in the top.
// TESTING
//  1. navg=0, en: report ch3 = 10'h155 -> next cycle o_avg_vld=1, ch=3, v=10'h155.
//  2. navg=2, ch0 reports 100,101,102,104 (sum 407) -> one pulse, v=(407+2)>>2=102.
//     No pulse on the first three reports.
//  3. navg=3, eight reports of 10'h3ff on ch17 -> v=10'h3ff, no overflow.
//     Interleave ch1 reports; ch1 is unaffected.
//  4. Window: WINLO=8'h40, WINHI=8'hc0, navg=0.
//     - ch2 report 10'h0fc (avg[9:2]=8'h3f): sta[2]=1, o_intr=1.
//     - AVGSTA write 8'h04 -> sta[2]=0.
//     - Write AVGSTA in the same cycle as a new out-of-window result: sta stays 1.
//  5. navg=2, two reports on ch5, then AVGCTL write with clr, then 4 reports
//     -> exactly one pulse. A report coincident with the write is dropped.
//  6. srst mid-accumulation after 3 of 4 reports -> all outputs 0.
//     After reset with en=0, a report gives no pulse; i_rpt_ch=25 is ignored.

Source files
------------

// File: rtl/sar_avg_pkg.sv
// Shared definitions for the post-SAR averaging block: SFR strobe map,
// AVGCTL bit positions, datapath widths and small arithmetic helpers.
package sar_avg_pkg;

    localparam int ACC_W = 13;
    localparam int CNT_W = 3;
    localparam int V_W   = 10;

    // AVGCTL bit positions
    localparam int CTL_CLR     = 0;
    localparam int CTL_NAVG_LO = 1;
    localparam int CTL_NAVG_HI = 2;
    localparam int CTL_EN      = 3;

    // SFR write strobe index map
    localparam int WR_AVGCTL = 0;
    localparam int WR_WINLO  = 1;
    localparam int WR_WINHI  = 2;
    localparam int WR_AVGSTA = 3;

    // Count value of the report that completes a block of 2^navg reports.
    function automatic logic [CNT_W-1:0] cnt_last(input logic [1:0] navg);
        case (navg)
            2'd0:    cnt_last = 3'd0;
            2'd1:    cnt_last = 3'd1;
            2'd2:    cnt_last = 3'd3;
            2'd3:    cnt_last = 3'd7;
            default: cnt_last = 3'd7;
        endcase
    endfunction

    // Round-half-up divide by 2^navg; the 13-bit sum leaves headroom for the
    // rounding constant, so the shifted result always fits in 10 bits.
    function automatic logic [V_W-1:0] round_avg(input logic [ACC_W-1:0] sum,
                                                  input logic [1:0]       navg);
        case (navg)
            2'd0:    round_avg = 10'(sum);
            2'd1:    round_avg = 10'((sum + 13'd1) >> 1);
            2'd2:    round_avg = 10'((sum + 13'd2) >> 2);
            2'd3:    round_avg = 10'((sum + 13'd4) >> 3);
            default: round_avg = 10'(sum);
        endcase
    endfunction

endpackage

// File: rtl/sar_avg_win.sv
// Window comparator with sticky, write-one-to-clear status bits.
// Present only in builds with SAR_AVG_WINDOW_EN defined. The status bit is
// set from the next-state average so it rises on the same edge as o_avg_vld.
module sar_avg_win
    import sar_avg_pkg::*;
#(
    parameter int BIT_PTR = 5,
    parameter int N_STA   = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               wr_lo_i,
    input  logic               wr_hi_i,
    input  logic               wr_sta_i,
    input  logic [7:0]         wdat_i,
    input  logic               avg_vld_i,
    input  logic [BIT_PTR-1:0] avg_ch_i,
    input  logic [V_W-1:0]     avg_v_i,
    output logic [7:0]         winlo_o,
    output logic [7:0]         winhi_o,
    output logic [N_STA-1:0]   sta_o,
    output logic               intr_o
);

    logic [7:0]       winlo_q;
    logic [7:0]       winhi_q;
    logic [N_STA-1:0] sta_q;
    logic [N_STA-1:0] sta_d;
    logic [N_STA-1:0] set_s;
    logic [N_STA-1:0] clr_s;
    logic             out_s;
    logic             unused_s;

    assign unused_s = ^avg_v_i[1:0];

    // Out-of-window detect on the new average and status next-state (set wins)
    always_comb begin
        out_s = (avg_v_i[9:2] < winlo_q) || (avg_v_i[9:2] > winhi_q);
        set_s = {N_STA{1'b0}};
        for (int i = 0; i < N_STA; i++) begin
            if (avg_vld_i && out_s && (avg_ch_i == BIT_PTR'(i))) begin
                set_s[i] = 1'b1;
            end else begin
                set_s[i] = 1'b0;
            end
        end
        if (wr_sta_i) begin
            clr_s = wdat_i[N_STA-1:0];
        end else begin
            clr_s = {N_STA{1'b0}};
        end
        sta_d = (sta_q & ~clr_s) | set_s;
    end

    // Window threshold registers and sticky status
    always_ff @(posedge clk) begin
        if (srst) begin
            winlo_q <= 8'h00;
            winhi_q <= 8'hff;
            sta_q   <= {N_STA{1'b0}};
        end else begin
            winlo_q <= wr_lo_i ? wdat_i : winlo_q;
            winhi_q <= wr_hi_i ? wdat_i : winhi_q;
            sta_q   <= sta_d;
        end
    end

    assign winlo_o = winlo_q;
    assign winhi_o = winhi_q;
    assign sta_o   = sta_q;
    assign intr_o  = |sta_q;

endmodule

// File: rtl/sar_avg.sv
// Post-SAR averaging stage: per-channel accumulate of 2^navg reports and a
// rounded 10-bit average. Optional window compare/status is enabled with the
// SAR_AVG_WINDOW_EN macro; without it WINLO/WINHI/AVGSTA read as zero.
module sar_avg
    import sar_avg_pkg::*;
#(
    parameter int BIT_PTR = 5,
    parameter int N_CHNL  = 18,
    parameter int N_STA   = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               i_rpt_vld,
    input  logic [BIT_PTR-1:0] i_rpt_ch,
    input  logic [V_W-1:0]     i_rpt_v,
    input  logic [3:0]         r_wr,
    input  logic [7:0]         r_wdat,
    output logic [7:0]         o_avgctl,
    output logic [7:0]         o_winlo,
    output logic [7:0]         o_winhi,
    output logic [N_STA-1:0]   o_avgsta,
    output logic               o_avg_vld,
    output logic [BIT_PTR-1:0] o_avg_ch,
    output logic [V_W-1:0]     o_avg_v,
    output logic               o_intr
);

    logic [ACC_W-1:0]   acc_q [N_CHNL];
    logic [CNT_W-1:0]   cnt_q [N_CHNL];
    logic [1:0]         navg_q;
    logic               en_q;
    logic               avg_vld_q;
    logic [BIT_PTR-1:0] avg_ch_q;
    logic [V_W-1:0]     avg_v_q;

    logic               avg_vld_d;
    logic [BIT_PTR-1:0] avg_ch_d;
    logic [V_W-1:0]     avg_v_d;

    logic               ctl_wr_s;
    logic               ch_ok_s;
    logic               accept_s;
    logic [ACC_W-1:0]   acc_sel_s;
    logic [CNT_W-1:0]   cnt_sel_s;
    logic [ACC_W-1:0]   sum_s;
    logic               last_s;

    // A control write clears all accumulators, so a coincident report is dropped.
    assign ctl_wr_s = r_wr[WR_AVGCTL];
    assign ch_ok_s  = (i_rpt_ch < BIT_PTR'(N_CHNL));
    assign accept_s = i_rpt_vld && en_q && ch_ok_s && !ctl_wr_s;

    // Select the addressed channel's accumulator and compute the new average
    always_comb begin
        acc_sel_s = {ACC_W{1'b0}};
        cnt_sel_s = {CNT_W{1'b0}};
        for (int i = 0; i < N_CHNL; i++) begin
            if (i_rpt_ch == BIT_PTR'(i)) begin
                acc_sel_s = acc_q[i];
                cnt_sel_s = cnt_q[i];
            end else begin
                acc_sel_s = acc_sel_s;
                cnt_sel_s = cnt_sel_s;
            end
        end
        sum_s     = acc_sel_s + ACC_W'(i_rpt_v);
        last_s    = (cnt_sel_s == cnt_last(navg_q));
        avg_vld_d = accept_s && last_s;
        if (avg_vld_d) begin
            avg_ch_d = i_rpt_ch;
            avg_v_d  = round_avg(sum_s, navg_q);
        end else begin
            avg_ch_d = avg_ch_q;
            avg_v_d  = avg_v_q;
        end
    end

    // AVGCTL register; the clr bit has no storage since every write clears
    always_ff @(posedge clk) begin
        if (srst) begin
            navg_q <= 2'd0;
            en_q   <= 1'b0;
        end else if (ctl_wr_s) begin
            navg_q <= r_wdat[CTL_NAVG_HI:CTL_NAVG_LO];
            en_q   <= r_wdat[CTL_EN];
        end else begin
            navg_q <= navg_q;
            en_q   <= en_q;
        end
    end

    // Per-channel accumulator bank, single-cycle read-modify-write
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CHNL; i++) begin
            if (srst || ctl_wr_s) begin
                acc_q[i] <= {ACC_W{1'b0}};
                cnt_q[i] <= {CNT_W{1'b0}};
            end else if (accept_s && (i_rpt_ch == BIT_PTR'(i))) begin
                if (last_s) begin
                    acc_q[i] <= {ACC_W{1'b0}};
                    cnt_q[i] <= {CNT_W{1'b0}};
                end else begin
                    acc_q[i] <= sum_s;
                    cnt_q[i] <= cnt_q[i] + 3'd1;
                end
            end else begin
                acc_q[i] <= acc_q[i];
                cnt_q[i] <= cnt_q[i];
            end
        end
    end

    // Registered average outputs
    always_ff @(posedge clk) begin
        if (srst) begin
            avg_vld_q <= 1'b0;
            avg_ch_q  <= {BIT_PTR{1'b0}};
            avg_v_q   <= {V_W{1'b0}};
        end else begin
            avg_vld_q <= avg_vld_d;
            avg_ch_q  <= avg_ch_d;
            avg_v_q   <= avg_v_d;
        end
    end

    assign o_avgctl  = {5'd0, en_q, navg_q};
    assign o_avg_vld = avg_vld_q;
    assign o_avg_ch  = avg_ch_q;
    assign o_avg_v   = avg_v_q;

`ifdef SAR_AVG_WINDOW_EN
    sar_avg_win #(
        .BIT_PTR (BIT_PTR),
        .N_STA   (N_STA)
    ) u_win (
        .clk       (clk),
        .srst      (srst),
        .wr_lo_i   (r_wr[WR_WINLO]),
        .wr_hi_i   (r_wr[WR_WINHI]),
        .wr_sta_i  (r_wr[WR_AVGSTA]),
        .wdat_i    (r_wdat),
        .avg_vld_i (avg_vld_d),
        .avg_ch_i  (avg_ch_d),
        .avg_v_i   (avg_v_d),
        .winlo_o   (o_winlo),
        .winhi_o   (o_winhi),
        .sta_o     (o_avgsta),
        .intr_o    (o_intr)
    );
`else
    logic unused_s;

    assign unused_s = ^{r_wr[WR_AVGSTA:WR_WINLO], r_wdat[7:4], r_wdat[CTL_CLR]};
    assign o_winlo  = 8'h00;
    assign o_winhi  = 8'h00;
    assign o_avgsta = {N_STA{1'b0}};
    assign o_intr   = 1'b0;
`endif

endmodule

// File: tb/tb_sar_avg.sv
// Directed, table-driven bench for sar_avg plus hand sequences for window
// status, reset mid-accumulation and channel-range corners.
module tb_sar_avg;

    localparam int BIT_PTR = 5;
    localparam int N_CHNL  = 18;
    localparam int N_STA   = 8;
`ifdef SAR_AVG_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               srst;
    logic               i_rpt_vld;
    logic [BIT_PTR-1:0] i_rpt_ch;
    logic [9:0]         i_rpt_v;
    logic [3:0]         r_wr;
    logic [7:0]         r_wdat;
    logic [7:0]         o_avgctl;
    logic [7:0]         o_winlo;
    logic [7:0]         o_winhi;
    logic [N_STA-1:0]   o_avgsta;
    logic               o_avg_vld;
    logic [BIT_PTR-1:0] o_avg_ch;
    logic [9:0]         o_avg_v;
    logic               o_intr;

    always #5 clk = ~clk;

    sar_avg #(.BIT_PTR(BIT_PTR), .N_CHNL(N_CHNL), .N_STA(N_STA)) dut (
        .clk(clk), .srst(srst), .i_rpt_vld(i_rpt_vld), .i_rpt_ch(i_rpt_ch),
        .i_rpt_v(i_rpt_v), .r_wr(r_wr), .r_wdat(r_wdat), .o_avgctl(o_avgctl),
        .o_winlo(o_winlo), .o_winhi(o_winhi), .o_avgsta(o_avgsta),
        .o_avg_vld(o_avg_vld), .o_avg_ch(o_avg_ch), .o_avg_v(o_avg_v),
        .o_intr(o_intr)
    );

    typedef struct {
        logic [3:0] wr;
        logic [7:0] wdat;
        logic       vld;
        logic [4:0] ch;
        logic [9:0] v;
        logic       e_vld;
        logic [4:0] e_ch;
        logic [9:0] e_v;
        logic [7:0] e_ctl;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic [3:0] wr, input logic [7:0] wdat, input logic vld,
                       input logic [4:0] ch, input logic [9:0] v, input logic e_vld,
                       input logic [4:0] e_ch, input logic [9:0] e_v, input logic [7:0] e_ctl);
        vec_t t;
        t.wr = wr; t.wdat = wdat; t.vld = vld; t.ch = ch; t.v = v;
        t.e_vld = e_vld; t.e_ch = e_ch; t.e_v = e_v; t.e_ctl = e_ctl;
        tbl.push_back(t);
    endtask

    // Drive one cycle of inputs, advance past the edge, then return inputs to idle.
    task automatic op(input logic [3:0] wr, input logic [7:0] wdat, input logic vld,
                      input logic [4:0] ch, input logic [9:0] v);
        r_wr = wr; r_wdat = wdat; i_rpt_vld = vld; i_rpt_ch = ch; i_rpt_v = v;
        @(posedge clk);
        #1;
        r_wr = 4'h0; r_wdat = 8'h00; i_rpt_vld = 1'b0; i_rpt_ch = 5'd0; i_rpt_v = 10'd0;
    endtask

    initial begin
        srst = 1'b1; r_wr = 4'h0; r_wdat = 8'h00;
        i_rpt_vld = 1'b0; i_rpt_ch = 5'd0; i_rpt_v = 10'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ctl",   o_avgctl,  8'h00);
        chk("rst_winlo", o_winlo,   8'h00);
        chk("rst_winhi", o_winhi,   WIN ? 8'hff : 8'h00);
        chk("rst_sta",   o_avgsta,  8'h00);
        chk("rst_vld",   o_avg_vld, 1'b0);
        chk("rst_ch",    o_avg_ch,  5'd0);
        chk("rst_v",     o_avg_v,   10'd0);
        chk("rst_intr",  o_intr,    1'b0);
        srst = 1'b0;

        // navg=0 pass-through
        add(4'h1, 8'h08, 1'b0, 5'd0, 10'd0,      1'b0, 5'd0,  10'd0,     8'h04);
        add(4'h0, 8'h00, 1'b1, 5'd3, 10'h155,    1'b1, 5'd3,  10'h155,   8'h04);
        add(4'h0, 8'h00, 1'b0, 5'd0, 10'd0,      1'b0, 5'd3,  10'h155,   8'h04);
        // navg=2 rounding, pulse only on the fourth report
        add(4'h1, 8'h0c, 1'b0, 5'd0, 10'd0,      1'b0, 5'd3,  10'h155,   8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd0, 10'd100,    1'b0, 5'd3,  10'h155,   8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd0, 10'd101,    1'b0, 5'd3,  10'h155,   8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd0, 10'd102,    1'b0, 5'd3,  10'h155,   8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd0, 10'd104,    1'b1, 5'd0,  10'd102,   8'h06);
        // navg=3 full-scale on ch17 interleaved with ch1 (1..8 -> (36+4)>>3=5)
        add(4'h1, 8'h0e, 1'b0, 5'd0, 10'd0,      1'b0, 5'd0,  10'd102,   8'h07);
        for (int k = 0; k < 7; k++) begin
            add(4'h0, 8'h00, 1'b1, 5'd17, 10'h3ff, 1'b0, 5'd0, 10'd102, 8'h07);
            add(4'h0, 8'h00, 1'b1, 5'd1, 10'(k + 1), 1'b0, 5'd0, 10'd102, 8'h07);
        end
        add(4'h0, 8'h00, 1'b1, 5'd17, 10'h3ff,   1'b1, 5'd17, 10'h3ff,   8'h07);
        add(4'h0, 8'h00, 1'b1, 5'd1,  10'd8,     1'b1, 5'd1,  10'd5,     8'h07);
        // clr mid-accumulation; coincident report dropped; (164+2)>>2=41
        add(4'h1, 8'h0c, 1'b0, 5'd0, 10'd0,      1'b0, 5'd1,  10'd5,     8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd5, 10'd10,     1'b0, 5'd1,  10'd5,     8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd5, 10'd20,     1'b0, 5'd1,  10'd5,     8'h06);
        add(4'h1, 8'h0d, 1'b1, 5'd5, 10'd30,     1'b0, 5'd1,  10'd5,     8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd5, 10'd40,     1'b0, 5'd1,  10'd5,     8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd5, 10'd40,     1'b0, 5'd1,  10'd5,     8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd5, 10'd40,     1'b0, 5'd1,  10'd5,     8'h06);
        add(4'h0, 8'h00, 1'b1, 5'd5, 10'd44,     1'b1, 5'd5,  10'd41,    8'h06);
        add(4'h0, 8'h00, 1'b0, 5'd0, 10'd0,      1'b0, 5'd5,  10'd41,    8'h06);

        for (int i = 0; i < tbl.size(); i++) begin
            op(tbl[i].wr, tbl[i].wdat, tbl[i].vld, tbl[i].ch, tbl[i].v);
            chk($sformatf("vec%0d_vld", i), o_avg_vld, tbl[i].e_vld);
            chk($sformatf("vec%0d_ch", i),  o_avg_ch,  tbl[i].e_ch);
            chk($sformatf("vec%0d_v", i),   o_avg_v,   tbl[i].e_v);
            chk($sformatf("vec%0d_ctl", i), o_avgctl,  tbl[i].e_ctl);
        end

        // Window compare and sticky W1C status
        op(4'h2, 8'h40, 1'b0, 5'd0, 10'd0);
        op(4'h4, 8'hc0, 1'b0, 5'd0, 10'd0);
        chk("win_lo_rb", o_winlo, WIN ? 8'h40 : 8'h00);
        chk("win_hi_rb", o_winhi, WIN ? 8'hc0 : 8'h00);
        op(4'h1, 8'h08, 1'b0, 5'd0, 10'd0);
        op(4'h0, 8'h00, 1'b1, 5'd2, 10'h0fc);
        chk("win_low_vld",  o_avg_vld, 1'b1);
        chk("win_low_v",    o_avg_v,   10'h0fc);
        chk("win_low_sta",  o_avgsta,  WIN ? 8'h04 : 8'h00);
        chk("win_low_intr", o_intr,    WIN);
        op(4'h0, 8'h00, 1'b0, 5'd0, 10'd0);
        chk("win_sticky",   o_avgsta,  WIN ? 8'h04 : 8'h00);
        op(4'h8, 8'h04, 1'b0, 5'd0, 10'd0);
        chk("win_w1c",      o_avgsta,  8'h00);
        chk("win_w1c_intr", o_intr,    1'b0);
        op(4'h8, 8'h04, 1'b1, 5'd2, 10'h0fc);
        chk("win_set_wins", o_avgsta,  WIN ? 8'h04 : 8'h00);
        chk("win_set_vld",  o_avg_vld, 1'b1);
        op(4'h0, 8'h00, 1'b1, 5'd3, 10'h200);
        chk("win_inside",   o_avgsta,  WIN ? 8'h04 : 8'h00);
        op(4'h0, 8'h00, 1'b1, 5'd1, 10'h300);
        chk("win_hi_edge",  o_avgsta,  WIN ? 8'h04 : 8'h00);
        op(4'h0, 8'h00, 1'b1, 5'd6, 10'h100);
        chk("win_lo_edge",  o_avgsta,  WIN ? 8'h04 : 8'h00);
        op(4'h0, 8'h00, 1'b1, 5'd0, 10'h3ff);
        chk("win_high",     o_avgsta,  WIN ? 8'h05 : 8'h00);
        op(4'h0, 8'h00, 1'b1, 5'd9, 10'h000);
        chk("win_nosta_ch", o_avgsta,  WIN ? 8'h05 : 8'h00);
        chk("win_nosta_v",  o_avg_v,   10'h000);

        // Reset after 3 of 4 reports
        op(4'h1, 8'h0c, 1'b0, 5'd0, 10'd0);
        op(4'h0, 8'h00, 1'b1, 5'd7, 10'd11);
        op(4'h0, 8'h00, 1'b1, 5'd7, 10'd12);
        op(4'h0, 8'h00, 1'b1, 5'd7, 10'd13);
        srst = 1'b1;
        op(4'h0, 8'h00, 1'b0, 5'd0, 10'd0);
        srst = 1'b0;
        chk("srst_ctl",  o_avgctl,  8'h00);
        chk("srst_vld",  o_avg_vld, 1'b0);
        chk("srst_ch",   o_avg_ch,  5'd0);
        chk("srst_v",    o_avg_v,   10'd0);
        chk("srst_sta",  o_avgsta,  8'h00);
        chk("srst_intr", o_intr,    1'b0);
        chk("srst_winlo", o_winlo,  8'h00);
        op(4'h0, 8'h00, 1'b1, 5'd7, 10'd13);
        chk("dis_vld", o_avg_vld, 1'b0);
        chk("dis_v",   o_avg_v,   10'd0);
        op(4'h1, 8'h08, 1'b0, 5'd0, 10'd0);
        op(4'h0, 8'h00, 1'b1, 5'd25, 10'h2aa);
        chk("ch25_vld", o_avg_vld, 1'b0);
        chk("ch25_ch",  o_avg_ch,  5'd0);
        op(4'h0, 8'h00, 1'b1, 5'd18, 10'h2aa);
        chk("ch18_vld", o_avg_vld, 1'b0);
        op(4'h0, 8'h00, 1'b1, 5'd17, 10'h2aa);
        chk("ch17_vld", o_avg_vld, 1'b1);
        chk("ch17_ch",  o_avg_ch,  5'd17);
        chk("ch17_v",   o_avg_v,   10'h2aa);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
